// File: rtl/factorial_engine.sv
// factorial_engine: sequential n! unit, one multiply per cycle, done/err handshake
// Optional feature macro: FACT_OVF_DETECT_EN (full 2*WIDTH product, saturate on overflow)
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous reset, active-low
//   go     - start request, sampled only in IDLE
//   n      - operand from the range checker
//   err_in - range-checker error flag, sampled with go
//   busy   - high while not in IDLE (registered)
//   done   - one-cycle completion pulse (registered)
//   err    - error status of last operation
//   result - n! of last operation, 0 on error, all ones on overflow
module factorial_engine #(
    parameter int WIDTH = 32,
    parameter int MAX_N = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [3:0]       n,
    input  logic             err_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [3:0] MAX_N4 = 4'(MAX_N);
    state_t state, state_nx;
    logic [WIDTH-1:0] product, mul;
    logic [3:0] cnt;
    logic bad_req, ovf, busy_nx, done_nx;
    assign bad_req = err_in || (n > MAX_N4);
`ifdef FACT_OVF_DETECT_EN
    logic [2*WIDTH-1:0] full;
    assign full = {{WIDTH{1'b0}}, product} * {{(2*WIDTH-4){1'b0}}, cnt};
    assign mul  = full[WIDTH-1:0];
    assign ovf  = |full[2*WIDTH-1:WIDTH];
`else
    assign mul = product * {{(WIDTH-4){1'b0}}, cnt};
    assign ovf = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE) ? (go ? (bad_req ? DONE : CALC) : IDLE) :
                   (state == CALC) ? ((cnt <= 4'd1 || ovf) ? DONE : CALC) : IDLE;
    end
    // busy/done are decoded from the next state so they can be registered
    always_comb begin
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            result  <= '0;
        end else if (state == IDLE && go) begin
            if (bad_req) begin
                err    <= 1'b1;
                result <= '0;
            end else begin
                product <= {{(WIDTH-1){1'b0}}, 1'b1};
                cnt     <= n;
                err     <= 1'b0;
            end
        end else if (state == CALC) begin
            if (ovf) begin
                err    <= 1'b1;
                result <= '1;
            end else if (cnt <= 4'd1) begin
                result <= product;
            end else begin
                product <= mul;
                cnt     <= cnt - 4'd1;
            end
        end
    end
endmodule
